// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of sig_in over GATE_CYCLES clocks.
// Optional FREQ_METER_HOLD_EN adds a hold input that suppresses publishing.
module freq_meter #(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int CNT_W       = 27
) (
    input  logic             clk_100mhz,
    input  logic             rst,
    input  logic             sig_in,
`ifdef FREQ_METER_HOLD_EN
    input  logic             hold,
`endif
    output logic [CNT_W-1:0] freq_count,
    output logic             ovf,
    output logic             valid
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] G_LAST = GW'(GATE_CYCLES - 1);

    typedef enum logic {
        WARMUP  = 1'b0,
        MEASURE = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && !(&v)) sat_inc = v + CNT_W'(1);
        else              sat_inc = v;
    endfunction

    function automatic logic sat_hit(input logic [CNT_W-1:0] v, input logic inc);
        sat_hit = inc && (&v);
    endfunction

    logic             s1, s2, s3;
    logic             edge_p;
    logic [GW-1:0]    gcnt;
    logic             end_win;
    logic [CNT_W-1:0] ecnt;
    logic             sat;
    logic [CNT_W-1:0] result;
    logic             result_ovf;
    logic             hold_act;
    logic             publish;
    state_t           state, state_nxt;

`ifdef FREQ_METER_HOLD_EN
    assign hold_act = hold;
`else
    assign hold_act = 1'b0;
`endif

    // Synchronizer stage: s1/s2 resolve metastability, s3 delays for edge detect
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_p  = s2 & ~s3;
    assign end_win = (gcnt == G_LAST);

    always_ff @(posedge clk_100mhz) begin
        if (rst || end_win) gcnt <= '0;
        else                gcnt <= gcnt + GW'(1);
    end

    // Counting stage: the end-of-window edge is folded into result, not into ecnt
    always_ff @(posedge clk_100mhz) begin
        if (rst || end_win) begin
            ecnt <= '0;
            sat  <= 1'b0;
        end else begin
            ecnt <= sat_inc(ecnt, edge_p);
            sat  <= sat | sat_hit(ecnt, edge_p);
        end
    end

    assign result     = sat_inc(ecnt, edge_p);
    assign result_ovf = sat | sat_hit(ecnt, edge_p);

    always_ff @(posedge clk_100mhz) begin
        if (rst) state <= WARMUP;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == WARMUP && end_win) state_nxt = MEASURE;
    end

    always_comb begin
        publish = (state == MEASURE) && end_win && !hold_act;
    end

    // Output stage: count, overflow and strobe are registered together
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            freq_count <= '0;
            ovf        <= 1'b0;
            valid      <= 1'b0;
        end else begin
            valid <= publish;
            if (publish) begin
                freq_count <= result;
                ovf        <= result_ovf;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Randomized scoreboard bench for freq_meter: a window-level edge model feeds
// per-DUT expectation queues that a negedge monitor drains.
module tb_freq_meter;

    localparam int G = 100;

    logic        clk_100mhz = 1'b0;
    logic        rst;
    logic        sig_in;
    logic        hold;
    logic [26:0] fc_a;
    logic [3:0]  fc_b;
    logic        ovf_a, ovf_b, vld_a, vld_b;

    always #5 clk_100mhz = ~clk_100mhz;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(27)) dut_a (
        .clk_100mhz(clk_100mhz),
        .rst       (rst),
        .sig_in    (sig_in),
`ifdef FREQ_METER_HOLD_EN
        .hold      (hold),
`endif
        .freq_count(fc_a),
        .ovf       (ovf_a),
        .valid     (vld_a)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut_b (
        .clk_100mhz(clk_100mhz),
        .rst       (rst),
        .sig_in    (sig_in),
`ifdef FREQ_METER_HOLD_EN
        .hold      (hold),
`endif
        .freq_count(fc_b),
        .ovf       (ovf_b),
        .valid     (vld_b)
    );

    typedef struct {
        longint cnt;
        bit     ovf;
        longint due;
    } exp_t;

    exp_t   q[2][$];
    longint last_cnt[2];
    bit     last_ovf[2];
    int     n_checks = 0;
    int     n_pass   = 0;
    bit     mon_en   = 1'b0;

    longint cyc;
    bit     prev;
    int     wcnt[longint];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: a rise sampled at cycle k is counted in cycle k+2's window;
    // window w is published at cycle (w+1)*G unless it is the warm-up window or held.
    always @(posedge clk_100mhz) begin
        longint w;
        longint n;
        exp_t   e;
        if (rst) begin
            cyc  = 0;
            prev = 1'b0;
            wcnt.delete();
            for (int d = 0; d < 2; d++) begin
                q[d].delete();
                last_cnt[d] = 0;
                last_ovf[d] = 1'b0;
            end
        end else begin
            if (sig_in && !prev) begin
                w = (cyc + 2) / G;
                if (wcnt.exists(w)) wcnt[w] = wcnt[w] + 1;
                else                wcnt[w] = 1;
            end
            prev = sig_in;
            if (cyc % G == G - 1) begin
                w = cyc / G;
                n = wcnt.exists(w) ? longint'(wcnt[w]) : 0;
                if (w >= 1 && !hold) begin
                    e.due = cyc + 1;
                    e.cnt = n;
                    e.ovf = 1'b0;
                    q[0].push_back(e);
                    e.cnt = (n > 15) ? 15 : n;
                    e.ovf = (n > 15);
                    q[1].push_back(e);
                end
                wcnt.delete(w);
            end
            cyc = cyc + 1;
        end
    end

    // Monitor: every cycle compares strobe, count and overflow against the model
    always @(negedge clk_100mhz) begin
        logic        v;
        logic [63:0] fc;
        logic        ov;
        bit          exp_v;
        exp_t        e;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                v  = (d == 0) ? vld_a : vld_b;
                fc = (d == 0) ? 64'(fc_a) : 64'(fc_b);
                ov = (d == 0) ? ovf_a : ovf_b;
                while (q[d].size() > 0 && q[d][0].due < cyc) void'(q[d].pop_front());
                exp_v = (q[d].size() > 0) && (q[d][0].due == cyc);
                if (exp_v) begin
                    e = q[d].pop_front();
                    last_cnt[d] = e.cnt;
                    last_ovf[d] = e.ovf;
                end
                check($sformatf("dut%0d_valid", d), 64'(v), 64'(exp_v));
                check($sformatf("dut%0d_freq_count", d), fc, 64'(last_cnt[d]));
                check($sformatf("dut%0d_ovf", d), 64'(ov), 64'(last_ovf[d]));
            end
        end
    end

    task automatic level(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = v;
            @(negedge clk_100mhz);
        end
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        int ph;
        ph = 0;
        for (int i = 0; i < n; i++) begin
            sig_in = (ph < hi);
            ph++;
            if (ph == hi + lo) ph = 0;
            @(negedge clk_100mhz);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk_100mhz);
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;
        hold   = 1'b0;
        repeat (3) @(negedge clk_100mhz);
        mon_en = 1'b1;
        rst    = 1'b0;

        level(1'b0, 450);
        wave(2, 2, 500);
        wave(5, 5, 400);
        wave(100, 100, 900);

        level(1'b1, 20);
        pulse_rst();
        level(1'b1, 250);
        wave(3, 3, 300);

        pulse_rst();
        wave(2, 2, 150);
        pulse_rst();
        wave(2, 2, 450);

        repeat (6) begin
            int hi, lo, n;
            hi = $urandom_range(12, 2);
            lo = $urandom_range(12, 2);
            n  = $urandom_range(400, 150);
            wave(hi, lo, n);
        end

`ifdef FREQ_METER_HOLD_EN
        wave(2, 2, 300);
        hold = 1'b1;
        wave(4, 4, 220);
        hold = 1'b0;
        wave(4, 4, 300);
`endif

        level(1'b0, 250);
        check("dut0_pending_publish", 64'(q[0].size()), 64'd0);
        check("dut1_pending_publish", 64'(q[1].size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
